mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single datacache port among the load and store reservation-station entries that are ready to access memory.
- Selects one requester at a time and sequences the cache read or write through a small FSM.
- Broadcasts each load result with its unit tag on the common data bus (CDB).
- Sits between the RS entry array and the datacache; the RS computes base+offset addresses and presents them here.

Parameters:
- N_LD, 4, number of load requesters.
- N_ST, 4, number of store requesters.
- WORD_SIZE, 32, address and data width.
- UNIT_SIZE, 8, tag width (RS unit code).
- CACHE_LAT, 2, cycles from cache strobe to valid cache_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ld_req  in  N_LD  load entry i has a resolved address
- ld_addr  in  N_LD*WORD_SIZE  load addresses; entry i at [i*WORD_SIZE +: WORD_SIZE]
- ld_tag  in  N_LD*UNIT_SIZE  unit code of each load entry
- ld_grant  out  N_LD  one-cycle one-hot grant pulse
- st_req  in  N_ST  store entry j has resolved address and data
- st_addr  in  N_ST*WORD_SIZE  store addresses
- st_data  in  N_ST*WORD_SIZE  store data
- st_grant  out  N_ST  one-cycle one-hot grant pulse
- st_done  out  1  one-cycle pulse when a store write completes
- cache_addr  out  WORD_SIZE  cache address
- cache_rd  out  1  read strobe
- cache_wr  out  1  write strobe
- cache_wdata  out  WORD_SIZE  write data
- cache_rdata  in  WORD_SIZE  read data
- cdb_valid  out  1  load result valid
- cdb_tag  out  UNIT_SIZE  producing unit code
- cdb_data  out  WORD_SIZE  loaded word
- cdb_ready  in  1  CDB accepts the result this cycle

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; any in-flight access or pending result is dropped.
  - All outputs go to 0.
  - ld_ptr and st_ptr go to 0; last_cls goes to STORE, so the first tie favours loads.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
- IDLE, when any request is present (selection, cycle t):
  - Choose a class:
    - Only one class requesting: that class.
    - Both requesting: the class opposite last_cls.
    - Override: if any requesting store has st_addr equal to any requesting load's ld_addr, STORE wins (read-after-write safety).
  - Within the class, rotating round-robin: the first requester at index ptr, ptr+1, … modulo N.
  - Pulse the grant bit for one cycle.
  - Latch addr, data (store) or tag (load), and the operation type.
  - Update ptr to winner+1 (mod N) and last_cls to the chosen class.
  - Go to ISSUE.
- Requesters must drop req in cycle t+1. A req still high at t+1 is treated as a new request.
- ISSUE (t+1): drive cache_addr and cache_wdata, and assert cache_rd or cache_wr for exactly this cycle. Go to WAIT with counter=1.
- WAIT (t+2 .. t+1+CACHE_LAT):
  - Increment the counter each cycle.
  - In cycle t+1+CACHE_LAT, a load captures cache_rdata and goes to RESULT.
  - A store pulses st_done in that same cycle and goes to IDLE.
- cache_addr holds its value from ISSUE through WAIT; strobes are 0 outside ISSUE.
- RESULT (from t+2+CACHE_LAT):
  - Hold cdb_valid=1 with stable cdb_tag and cdb_data.
  - On a cycle where cdb_ready=1, complete the transfer; next cycle cdb_valid=0 and the FSM is in IDLE.
  - Requests arriving meanwhile are not granted until IDLE.
- Throughput: at most one access per (CACHE_LAT+2) cycles for stores, and (CACHE_LAT+3)+stall cycles for loads. Back-to-back grants are never issued.
- Grants are mutually exclusive across both vectors; ld_grant|st_grant is at most one-hot.
- Address compare is full WORD_SIZE equality; no masking.
- Out-of-range ptr cannot occur; ptr wraps from N-1 to 0.

Decomposition:
- Shared define/package holds WORD_SIZE, UNIT_SIZE, the FSM state encoding (2 bits) and class codes (LD=0, ST=1).
- One natural sub-module, rr_pick: parameterised N, inputs req[N] and ptr, outputs one-hot grant and encoded index. Instantiate it twice (load and store).

Test Plan:
- Single load: ld_req[2]=1, ld_addr=0x40, tag=0x85, cache returns 0xDEADBEEF at strobe+2, cdb_ready=1.
  -> ld_grant=0100 at t, cache_rd at t+1 with addr 0x40, cdb_valid at t+4 with tag 0x85, data 0xDEADBEEF, for 1 cycle.
- Store: st_req[1]=1, addr=0x10, data=0x1234.
  -> st_grant=0010 at t, cache_wr=1 with wdata 0x1234 at t+1 only, st_done at t+3, IDLE at t+4.
- Both classes tie after reset: ld_req=0001 (addr 0x8), st_req=0001 (addr 0xC) held.
  -> load granted first, then store, then alternating.
- Conflict override: ld_req[0] and st_req[3] both at addr 0x20.
  -> st_grant=1000 first, the load afterwards.
- Round-robin: ld_req=1111 held, each request re-raised after its grant.
  -> grants in order 0001, 0010, 0100, 1000, 0001.
- Backpressure and reset:
  - cdb_ready=0 for 5 cycles -> cdb_valid and data stay stable, no new grant.
  - Assert rst in WAIT -> all outputs 0 immediately; the next request is granted from index 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, FSM encoding and class codes for the datacache port arbiter
package mem_port_arbiter_pkg;
  localparam int WORD_SIZE = 32;
  localparam int UNIT_SIZE = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  typedef enum logic {
    CLS_LD = 1'b0,
    CLS_ST = 1'b1
  } cls_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - rotating round-robin picker: first requester at ptr, ptr+1, ... mod N
module mem_port_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  int   j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the datacache port between load/store RS entries and drives load results onto the CDB
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_LD      = 4,
  parameter int N_ST      = 4,
  parameter int WORD_SIZE = mem_port_arbiter_pkg::WORD_SIZE,
  parameter int UNIT_SIZE = mem_port_arbiter_pkg::UNIT_SIZE,
  parameter int CACHE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_LD-1:0]           ld_req,
  input  logic [N_LD*WORD_SIZE-1:0] ld_addr,
  input  logic [N_LD*UNIT_SIZE-1:0] ld_tag,
  output logic [N_LD-1:0]           ld_grant,
  input  logic [N_ST-1:0]           st_req,
  input  logic [N_ST*WORD_SIZE-1:0] st_addr,
  input  logic [N_ST*WORD_SIZE-1:0] st_data,
  output logic [N_ST-1:0]           st_grant,
  output logic                      st_done,
  output logic [WORD_SIZE-1:0]      cache_addr,
  output logic                      cache_rd,
  output logic                      cache_wr,
  output logic [WORD_SIZE-1:0]      cache_wdata,
  input  logic [WORD_SIZE-1:0]      cache_rdata,
  output logic                      cdb_valid,
  output logic [UNIT_SIZE-1:0]      cdb_tag,
  output logic [WORD_SIZE-1:0]      cdb_data,
  input  logic                      cdb_ready
);
  localparam int LPW = (N_LD > 1) ? $clog2(N_LD) : 1;
  localparam int SPW = (N_ST > 1) ? $clog2(N_ST) : 1;
  localparam logic [3:0] LAT = 4'(CACHE_LAT);

  state_t               state, state_nx;
  cls_t                 last_cls, op_q;
  logic [LPW-1:0]       ld_ptr, ld_idx;
  logic [SPW-1:0]       st_ptr, st_idx;
  logic [N_LD-1:0]      ld_onehot;
  logic [N_ST-1:0]      st_onehot;
  logic [3:0]           cnt;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, rdata_q;
  logic [UNIT_SIZE-1:0] tag_q;
  logic                 conflict, pick_st, grant_en, lat_done;

  mem_port_arbiter_rr_pick #(.N(N_LD), .PW(LPW)) u_ld_pick (
    .req(ld_req), .ptr(ld_ptr), .grant(ld_onehot), .idx(ld_idx)
  );

  mem_port_arbiter_rr_pick #(.N(N_ST), .PW(SPW)) u_st_pick (
    .req(st_req), .ptr(st_ptr), .grant(st_onehot), .idx(st_idx)
  );

  // A store to an address some pending load wants must reach the cache first.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < N_LD; i++) begin
      for (int k = 0; k < N_ST; k++) begin
        if (ld_req[i] && st_req[k] &&
            ld_addr[i*WORD_SIZE +: WORD_SIZE] == st_addr[k*WORD_SIZE +: WORD_SIZE])
          conflict = 1'b1;
      end
    end
  end

  assign pick_st  = (|st_req) && (!(|ld_req) || conflict || last_cls == CLS_LD);
  assign grant_en = (state == S_IDLE) && !rst && ((|ld_req) || (|st_req));
  assign lat_done = (state == S_WAIT) && (cnt == LAT);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (grant_en) state_nx = S_ISSUE;
      S_ISSUE:  state_nx = S_WAIT;
      S_WAIT:   if (lat_done) state_nx = (op_q == CLS_LD) ? S_RESULT : S_IDLE;
      S_RESULT: if (cdb_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      last_cls <= CLS_ST;
      op_q     <= CLS_LD;
      ld_ptr   <= '0;
      st_ptr   <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      tag_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            if (pick_st) begin
              op_q     <= CLS_ST;
              last_cls <= CLS_ST;
              addr_q   <= st_addr[st_idx*WORD_SIZE +: WORD_SIZE];
              wdata_q  <= st_data[st_idx*WORD_SIZE +: WORD_SIZE];
              st_ptr   <= (st_idx == SPW'(N_ST-1)) ? '0 : st_idx + SPW'(1);
            end else begin
              op_q     <= CLS_LD;
              last_cls <= CLS_LD;
              addr_q   <= ld_addr[ld_idx*WORD_SIZE +: WORD_SIZE];
              tag_q    <= ld_tag[ld_idx*UNIT_SIZE +: UNIT_SIZE];
              ld_ptr   <= (ld_idx == LPW'(N_LD-1)) ? '0 : ld_idx + LPW'(1);
            end
          end
        end
        S_ISSUE: cnt <= 4'd1;
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          if (lat_done && op_q == CLS_LD) rdata_q <= cache_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ld_grant    = (grant_en && !pick_st) ? ld_onehot : '0;
  assign st_grant    = (grant_en &&  pick_st) ? st_onehot : '0;
  assign cache_rd    = (state == S_ISSUE) && (op_q == CLS_LD);
  assign cache_wr    = (state == S_ISSUE) && (op_q == CLS_ST);
  assign cache_addr  = (state == S_ISSUE || state == S_WAIT) ? addr_q : '0;
  assign cache_wdata = ((state == S_ISSUE || state == S_WAIT) && op_q == CLS_ST) ? wdata_q : '0;
  assign st_done     = lat_done && (op_q == CLS_ST);
  assign cdb_valid   = (state == S_RESULT);
  assign cdb_tag     = cdb_valid ? tag_q : '0;
  assign cdb_data    = cdb_valid ? rdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized check of mem_port_arbiter against a transaction-timeline model
module tb_mem_port_arbiter;
  localparam int NL = 4, NS = 4, W = 32, U = 8, L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NL-1:0] ld_req = '0, ld_grant;
  logic [NL*W-1:0] ld_addr = '0;
  logic [NL*U-1:0] ld_tag = '0;
  logic [NS-1:0] st_req = '0, st_grant;
  logic [NS*W-1:0] st_addr = '0, st_data = '0;
  logic st_done, cache_rd, cache_wr, cdb_valid;
  logic cdb_ready = 1'b1;
  logic [W-1:0] cache_addr, cache_wdata, cdb_data;
  logic [W-1:0] cache_rdata = '0;
  logic [U-1:0] cdb_tag;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_LD(NL), .N_ST(NS), .WORD_SIZE(W), .UNIT_SIZE(U), .CACHE_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_tag(ld_tag), .ld_grant(ld_grant),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_grant(st_grant), .st_done(st_done),
    .cache_addr(cache_addr), .cache_rd(cache_rd), .cache_wr(cache_wr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ready(cdb_ready)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;

  // requester side of the environment
  logic [NL-1:0] lp = '0;
  logic [NS-1:0] sp = '0;
  logic [W-1:0]  la[NL], sa[NS], sd[NS];
  logic [U-1:0]  lt[NL];
  bit hold_ld = 0, hold_st = 0;
  logic ready_drv = 1'b1;

  // model: a granted access is described by the cycle count k since its grant
  bit m_busy = 0, m_st = 0, m_last_st = 1;
  int m_k = 0, m_lp = 0, m_sp = 0;
  logic [W-1:0] m_addr = '0, m_data = '0;
  logic [U-1:0] m_tag = '0;

  logic [7:0] glog[$];
  int g_cyc, rd_cyc, wr_cyc, done_cyc, cdb_cyc, cdb_cnt, wr_cnt;
  logic [W-1:0] rd_addr, wdata_seen, cdb_d;
  logic [U-1:0] cdb_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mem(input logic [W-1:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return a * 32'h9E3779B1 + 32'd1;
  endfunction

  function automatic int rr(input logic [3:0] r, input int p);
    for (int i = p; i < 4; i++) if (r[i]) return i;
    for (int i = 0; i < p; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic m_pick(output bit any, output bit is_st, output int idx);
    bit conflict = 0;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NS; j++)
        if (lp[i] && sp[j] && la[i] == sa[j]) conflict = 1;
    any   = (lp != 0) || (sp != 0);
    is_st = (sp != 0) && ((lp == 0) || conflict || !m_last_st);
    idx   = is_st ? rr(sp, m_sp) : rr(lp, m_lp);
  endtask

  task automatic clear_log();
    glog.delete();
    g_cyc = -100; rd_cyc = -100; wr_cyc = -100; done_cyc = -100; cdb_cyc = -100;
    cdb_cnt = 0; wr_cnt = 0; rd_addr = '0; wdata_seen = '0; cdb_d = '0; cdb_t = '0;
  endtask

  task automatic tick();
    logic [NL-1:0] e_lg;
    logic [NS-1:0] e_sg;
    logic [W-1:0]  e_addr;
    bit any, ist, e_rd, e_wr, e_done, e_cv;
    int idx;
    ld_req = lp; st_req = sp; cdb_ready = ready_drv;
    for (int i = 0; i < NL; i++) begin ld_addr[i*W +: W] = la[i]; ld_tag[i*U +: U] = lt[i]; end
    for (int i = 0; i < NS; i++) begin st_addr[i*W +: W] = sa[i]; st_data[i*W +: W] = sd[i]; end
    cache_rdata = (m_busy && !m_st && m_k == L + 1) ? mem(m_addr) : $urandom;
    #1;
    e_lg = '0; e_sg = '0; e_addr = '0; any = 0; ist = 0; idx = 0;
    e_rd = 0; e_wr = 0; e_done = 0; e_cv = 0;
    if (!rst && !m_busy) begin
      m_pick(any, ist, idx);
      if (any && ist) e_sg[idx] = 1'b1;
      if (any && !ist) e_lg[idx] = 1'b1;
    end
    if (!rst && m_busy) begin
      e_rd   = !m_st && m_k == 1;
      e_wr   = m_st && m_k == 1;
      e_addr = (m_k >= 1 && m_k <= L + 1) ? m_addr : '0;
      e_done = m_st && m_k == L + 1;
      e_cv   = !m_st && m_k >= L + 2;
    end
    chk("ld_grant", 64'(ld_grant), 64'(e_lg));
    chk("st_grant", 64'(st_grant), 64'(e_sg));
    chk("cache_rd", 64'(cache_rd), 64'(e_rd));
    chk("cache_wr", 64'(cache_wr), 64'(e_wr));
    chk("cache_addr", 64'(cache_addr), 64'(e_addr));
    chk("st_done", 64'(st_done), 64'(e_done));
    chk("cdb_valid", 64'(cdb_valid), 64'(e_cv));
    if (e_wr) chk("cache_wdata", 64'(cache_wdata), 64'(m_data));
    if (e_cv) begin
      chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
      chk("cdb_data", 64'(cdb_data), 64'(mem(m_addr)));
    end
    if (rst) begin
      chk("rst_wdata", 64'(cache_wdata), 64'd0);
      chk("rst_cdb", 64'({cdb_tag, cdb_data}), 64'd0);
    end
    if ((ld_grant | st_grant) != 0) begin
      if (glog.size() == 0) g_cyc = cyc;
      glog.push_back({|st_grant, 3'b000, ld_grant | st_grant});
    end
    if (cache_rd) begin rd_cyc = cyc; rd_addr = cache_addr; end
    if (cache_wr) begin wr_cyc = cyc; wdata_seen = cache_wdata; wr_cnt++; end
    if (st_done) done_cyc = cyc;
    if (cdb_valid) begin
      if (cdb_cnt == 0) cdb_cyc = cyc;
      cdb_cnt++; cdb_t = cdb_tag; cdb_d = cdb_data;
    end
    if (rst) begin
      m_busy = 0; m_last_st = 1; m_lp = 0; m_sp = 0;
    end else if (!m_busy) begin
      if (any) begin
        m_busy = 1; m_k = 1; m_st = ist; m_last_st = ist;
        if (ist) begin m_addr = sa[idx]; m_data = sd[idx]; m_sp = (idx + 1) % NS; end
        else     begin m_addr = la[idx]; m_tag = lt[idx]; m_lp = (idx + 1) % NL; end
        if (ist && !hold_st) sp[idx] = 1'b0;
        if (!ist && !hold_ld) lp[idx] = 1'b0;
      end
    end else if (m_st && m_k == L + 1) m_busy = 0;
    else if (!m_st && m_k >= L + 2 && cdb_ready) m_busy = 0;
    else m_k++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    lp = '0; sp = '0; hold_ld = 0; hold_st = 0; ready_drv = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin la[i] = '0; lt[i] = '0; end
    for (int i = 0; i < NS; i++) begin sa[i] = '0; sd[i] = '0; end
    clear_log();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // single load
    clear_log();
    lp[2] = 1'b1; la[2] = 32'h40; lt[2] = 8'h85;
    repeat (8) tick();
    chk("ld1_ngrant", 64'(glog.size()), 64'd1);
    chk("ld1_grant", 64'((glog.size() > 0) ? glog[0] : 8'hFF), 64'h04);
    chk("ld1_rd_lat", 64'(rd_cyc - g_cyc), 64'd1);
    chk("ld1_rd_addr", 64'(rd_addr), 64'h40);
    chk("ld1_cdb_lat", 64'(cdb_cyc - g_cyc), 64'd4);
    chk("ld1_cdb_tag", 64'(cdb_t), 64'h85);
    chk("ld1_cdb_data", 64'(cdb_d), 64'hDEADBEEF);
    chk("ld1_cdb_len", 64'(cdb_cnt), 64'd1);

    // single store
    clear_log();
    sp[1] = 1'b1; sa[1] = 32'h10; sd[1] = 32'h1234;
    repeat (6) tick();
    chk("st1_grant", 64'((glog.size() > 0) ? glog[0] : 8'hFF), 64'h82);
    chk("st1_wr_lat", 64'(wr_cyc - g_cyc), 64'd1);
    chk("st1_wdata", 64'(wdata_seen), 64'h1234);
    chk("st1_done_lat", 64'(done_cyc - g_cyc), 64'd3);
    chk("st1_wr_cnt", 64'(wr_cnt), 64'd1);

    // tie after reset alternates, load first
    pulse_reset();
    clear_log();
    hold_ld = 1; hold_st = 1;
    lp = 4'b0001; la[0] = 32'h8; sp = 4'b0001; sa[0] = 32'hC;
    for (int i = 0; i < 60 && glog.size() < 4; i++) tick();
    drain(10);
    chk("tie_n", 64'(glog.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      chk("tie_seq", 64'((glog.size() > i) ? glog[i] : 8'hFF), 64'((i % 2) ? 8'h81 : 8'h01));

    // same-address conflict: store wins even though loads are due
    clear_log();
    lp[0] = 1'b1; la[0] = 32'h20; sp[3] = 1'b1; sa[3] = 32'h20; sd[3] = 32'h55;
    repeat (20) tick();
    chk("cfl_n", 64'(glog.size()), 64'd2);
    chk("cfl_first", 64'((glog.size() > 0) ? glog[0] : 8'hFF), 64'h88);
    chk("cfl_second", 64'((glog.size() > 1) ? glog[1] : 8'hFF), 64'h01);

    // round robin over all loads
    pulse_reset();
    clear_log();
    hold_ld = 1;
    for (int i = 0; i < NL; i++) la[i] = 32'h100 + 32'(i * 4);
    lp = 4'b1111;
    for (int i = 0; i < 60 && glog.size() < 5; i++) tick();
    drain(10);
    chk("rr_n", 64'(glog.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      chk("rr_seq", 64'((glog.size() > i) ? glog[i] : 8'hFF), 64'(8'h01 << (i % 4)));

    // backpressure: result held, store must wait
    clear_log();
    ready_drv = 1'b0;
    lp[1] = 1'b1; la[1] = 32'h44; lt[1] = 8'h3C;
    for (int i = 0; i < 20 && cdb_cnt == 0; i++) tick();
    sp[0] = 1'b1; sa[0] = 32'h50; sd[0] = 32'h77;
    repeat (5) tick();
    chk("bp_cdb_len", 64'(cdb_cnt), 64'd6);
    chk("bp_nogrant", 64'(glog.size()), 64'd1);
    ready_drv = 1'b1;
    repeat (10) tick();
    chk("bp_after_n", 64'(glog.size()), 64'd2);
    chk("bp_after", 64'((glog.size() > 1) ? glog[1] : 8'hFF), 64'h81);

    // reset during WAIT, then pointer restarts at 0
    clear_log();
    lp[1] = 1'b1; la[1] = 32'h60; lt[1] = 8'h11;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    lp = 4'b1010; la[1] = 32'h64; la[3] = 32'h68;
    tick();
    chk("rst_n", 64'(glog.size()), 64'd2);
    chk("rst_regrant", 64'((glog.size() > 1) ? glog[1] : 8'hFF), 64'h02);
    chk("rst_no_rd", 64'(rd_cyc == g_cyc + 1 && rd_cyc < cyc - 2), 64'd1);
    repeat (12) tick();
    drain(10);

    // randomized traffic with conflicts, backpressure and one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NL; i++)
        if (!lp[i] && $urandom_range(0, 7) == 0) begin
          lp[i] = 1'b1; la[i] = 32'($urandom_range(0, 7) * 4); lt[i] = 8'($urandom);
        end
      for (int i = 0; i < NS; i++)
        if (!sp[i] && $urandom_range(0, 7) == 0) begin
          sp[i] = 1'b1; sa[i] = 32'($urandom_range(0, 7) * 4); sd[i] = $urandom;
        end
      ready_drv = ($urandom_range(0, 3) != 0);
      rst = (c == 1500 || c == 1501);
      tick();
    end
    rst = 1'b0;
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
